// File: rtl/timer_period_monitor.sv
// timer_period_monitor: measures spacing of timer trigger pulses,
// flags early/late intervals, counts errors and reports lock.
module timer_period_monitor #(
    parameter int WIDTH      = 7,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 trigger,
    input  logic [WIDTH-1:0]     expected_period,
    input  logic                 clear_errors,
    output logic [WIDTH-1:0]     measured,
    output logic                 sample_valid,
    output logic                 match,
    output logic                 late,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam int RUN_WIDTH = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_WIDTH-1:0] RUN_FULL = RUN_WIDTH'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     count;
    logic [RUN_WIDTH-1:0] run;
    logic                 capture;
    logic                 overdue;
    logic                 hit;
    logic                 early;
    logic                 err_inc;

    assign hit     = (count == expected_period);
    assign early   = (count < expected_period);
    assign err_inc = overdue | (capture & early & ~late);
    assign locked  = (run == RUN_FULL);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus capture / overdue strobes; enable low overrides all
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        overdue    = 1'b0;
        case (state)
            IDLE: begin
                state_next = ARM;
            end
            ARM: begin
                if (trigger) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                capture = trigger;
                overdue = !trigger && hit && !late;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
            capture    = 1'b0;
            overdue    = 1'b0;
        end
    end

    // Interval counter, capture registers, late flag and match run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            run          <= '0;
            measured     <= '0;
            sample_valid <= 1'b0;
            match        <= 1'b0;
            late         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!enable) begin
                count <= '0;
                late  <= 1'b0;
                run   <= '0;
            end else if (state != MEASURE) begin
                count <= '0;
            end else if (capture) begin
                measured     <= count;
                sample_valid <= 1'b1;
                match        <= hit;
                count        <= '0;
                late         <= 1'b0;
                if (hit && !late) begin
                    if (run != RUN_FULL) begin
                        run <= run + 1'b1;
                    end
                end else begin
                    run <= '0;
                end
            end else begin
                if (count != CNT_MAX) begin
                    count <= count + 1'b1;
                end
                if (overdue) begin
                    late <= 1'b1;
                    run  <= '0;
                end
            end
        end
    end

    // Saturating error counter; clear wins over a same-edge increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clear_errors) begin
            err_count <= '0;
        end else if (err_inc && err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule
